// File: rtl/vend_seq_ctrl.sv
// vend_seq_ctrl: sequencing controller for the coin-operated bottle vending datapath.
// Captures 5/10 coin pulses into a small queue (two writes per cycle), accumulates
// credit one coin per cycle, runs the dispense handshake, returns change in 5-unit
// pulses and tracks bottle inventory.
// Optional build macro: VEND_TIMEOUT_EN adds an idle-credit timeout in ACCUM that
// refunds all credit after TIMEOUT_CYC cycles without a coin.
module vend_seq_ctrl #(
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 6,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_5,
    input  logic                in_10,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                restock,
    output logic                out_bottle,
    output logic                out_change_5,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out,
    output logic                busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN_C   = CREDIT_W'(10);
    localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);

    // Reject the build outright if the parameter set cannot work.
    if ((PRICE <= 0) || ((PRICE % 5) != 0) || ((1 << CREDIT_W) <= (PRICE + 5)) ||
        (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (STOCK_INIT < 0) || (STOCK_INIT >= (1 << STOCK_W)) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("vend_seq_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DISPENSE,
        CHANGE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [STOCK_W-1:0]  stock;
    logic [STOCK_W-1:0]  stock_n;

    // Coin queue: one bit per entry, 1 = 10-unit coin, 0 = 5-unit coin.
    logic [FIFO_DEPTH-1:0] fifo_mem;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      free;
    logic                  pop;
    logic                  head_ten;
    logic [CREDIT_W-1:0]   coin_val;

    logic                  c0_valid;
    logic                  c0_ten;
    logic                  c1_valid;
    logic                  wr0;
    logic                  wr1;
    logic [1:0]            drop_n;

    // Each dropped coin holds coin_reject high for one cycle, so two coins lost in
    // the same cycle give two consecutive reject cycles.
    logic [2:0]            reject_cnt;
    logic [2:0]            reject_cnt_n;
    logic [3:0]            reject_sum;

    logic                  timeout;

    assign out_bottle   = (state == DISPENSE);
    assign out_change_5 = (state == CHANGE);
    assign busy         = (state == DISPENSE) || (state == CHANGE);
    assign sold_out     = (stock == '0);
    assign coin_reject  = (reject_cnt != '0);

    assign head_ten = fifo_mem[rd_ptr];
    assign coin_val = head_ten ? TEN_C : FIVE_C;

    // Coin capture: order simultaneous coins 5 first, admit as many as fit after this cycle's pop.
    always_comb begin
        c0_valid     = in_5 | in_10;
        c0_ten       = ~in_5;
        c1_valid     = in_5 & in_10;
        free         = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
        wr0          = c0_valid && (free != '0);
        wr1          = c1_valid && (free >= CNT_W'(2));
        drop_n       = 2'(c0_valid & ~wr0) + 2'(c1_valid & ~wr1);
        reject_sum   = {1'b0, reject_cnt} - 4'(reject_cnt != '0) + 4'(drop_n);
        reject_cnt_n = (reject_sum > 4'd7) ? 3'd7 : reject_sum[2:0];
    end

    // Coin queue storage, pointers, occupancy and pending-reject counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            reject_cnt <= '0;
        end else begin
            if (wr0) begin
                fifo_mem[wr_ptr] <= c0_ten;
            end
            if (wr1) begin
                fifo_mem[wr_ptr + PTR_W'(1)] <= 1'b1;
            end
            wr_ptr     <= wr_ptr + PTR_W'(wr0) + PTR_W'(wr1);
            rd_ptr     <= rd_ptr + PTR_W'(pop);
            count      <= count - CNT_W'(pop) + CNT_W'(wr0) + CNT_W'(wr1);
            reject_cnt <= reject_cnt_n;
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Idle-credit timer: counts ACCUM cycles since the last popped coin.
    always_ff @(posedge clk) begin
        if (rst || (state != ACCUM) || pop) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timeout = (state == ACCUM) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    // State, credit and inventory registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            credit <= '0;
            stock  <= STOCK_C;
        end else begin
            state  <= state_n;
            credit <= credit_n;
            stock  <= stock_n;
        end
    end

    // Next-state, credit and stock logic; cancel and timeout take priority over popping.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        stock_n  = stock;
        pop      = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if ((state == IDLE) && restock) begin
                    stock_n = STOCK_C;
                end
                if ((state == ACCUM) && (cancel || timeout)) begin
                    state_n = CHANGE;
                end else if (count != '0) begin
                    pop      = 1'b1;
                    credit_n = credit + coin_val;
                    if (!sold_out && (credit_n >= PRICE_C)) begin
                        state_n = DISPENSE;
                    end else if (sold_out) begin
                        state_n = CHANGE;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            DISPENSE: begin
                if (disp_ack) begin
                    credit_n = credit - PRICE_C;
                    if (stock != '0) begin
                        stock_n = stock - STOCK_W'(1);
                    end
                    state_n = (credit_n != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                credit_n = (credit >= FIVE_C) ? (credit - FIVE_C) : '0;
                if (credit_n == '0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// tb_vend_seq_ctrl: directed-vector scoreboard bench for vend_seq_ctrl.
// Stimulus pushes expected credit values, dispense requests, change pulses and
// coin rejects into queues; a monitor pops and compares on every observed event.
module tb_vend_seq_ctrl;

    localparam int PRICE   = 15;
    localparam int TMO_CYC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_5 = 1'b0;
    logic       in_10 = 1'b0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       restock = 1'b0;
    logic       out_bottle;
    logic       out_change_5;
    logic       coin_reject;
    logic [5:0] credit;
    logic       sold_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int credit_q[$];
    int bottle_q[$];
    int change_q[$];
    int reject_q[$];

    bit mon_en = 1'b0;
    int prev_credit = 0;
    bit prev_bottle = 1'b0;

    always #5 clk = ~clk;

    vend_seq_ctrl #(
        .PRICE(PRICE),
        .CREDIT_W(6),
        .STOCK_W(4),
        .STOCK_INIT(10),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYC(TMO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_5(in_5),
        .in_10(in_10),
        .cancel(cancel),
        .disp_ack(disp_ack),
        .restock(restock),
        .out_bottle(out_bottle),
        .out_change_5(out_change_5),
        .coin_reject(coin_reject),
        .credit(credit),
        .sold_out(sold_out),
        .busy(busy)
    );

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Monitor: compare every observed DUT event against the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(credit) != prev_credit) begin
                checks++;
                if (credit_q.size() == 0) begin
                    errors++;
                    $display("FAIL credit: unexpected change to %0d (nothing expected)", credit);
                end else begin
                    int exp_c;
                    exp_c = credit_q.pop_front();
                    if (int'(credit) != exp_c) begin
                        errors++;
                        $display("FAIL credit: got %0d expected %0d", credit, exp_c);
                    end
                end
            end
            if (out_bottle && !prev_bottle) begin
                checks++;
                if (bottle_q.size() == 0) begin
                    errors++;
                    $display("FAIL bottle: unexpected dispense request at credit %0d", credit);
                end else begin
                    int exp_b;
                    exp_b = bottle_q.pop_front();
                    if (int'(credit) != exp_b) begin
                        errors++;
                        $display("FAIL bottle: credit at request %0d expected %0d", credit, exp_b);
                    end
                end
            end
            if (out_change_5) begin
                checks++;
                if (change_q.size() == 0) begin
                    errors++;
                    $display("FAIL change: unexpected change pulse at credit %0d", credit);
                end else begin
                    int exp_ch;
                    exp_ch = change_q.pop_front();
                    if (int'(credit) != exp_ch) begin
                        errors++;
                        $display("FAIL change: credit during pulse %0d expected %0d", credit, exp_ch);
                    end
                end
            end
            if (coin_reject) begin
                checks++;
                if (reject_q.size() == 0) begin
                    errors++;
                    $display("FAIL reject: unexpected coin_reject cycle");
                end else begin
                    void'(reject_q.pop_front());
                end
            end
            prev_credit = int'(credit);
            prev_bottle = out_bottle;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin(input bit c5, input bit c10);
        in_5  = c5;
        in_10 = c10;
        tick(1);
        in_5  = 1'b0;
        in_10 = 1'b0;
    endtask

    task automatic wait_bottle();
        int n;
        n = 0;
        while (!out_bottle && (n < 50)) begin
            tick(1);
            n++;
        end
        checks++;
        if (!out_bottle) begin
            errors++;
            $display("FAIL wait_bottle: out_bottle %0d after %0d cycles, required 1", out_bottle, n);
        end
    endtask

    task automatic ack();
        check("bottle_before_ack", int'(out_bottle), 1);
        disp_ack = 1'b1;
        tick(1);
        disp_ack = 1'b0;
    endtask

    task automatic vend_10_5();
        credit_q.push_back(10);
        credit_q.push_back(15);
        credit_q.push_back(0);
        bottle_q.push_back(15);
        coin(1'b0, 1'b1);
        tick(3);
        coin(1'b1, 1'b0);
        wait_bottle();
        tick(1);
        ack();
        tick(2);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_credit", int'(credit), 0);
        check("rst_bottle", int'(out_bottle), 0);
        check("rst_change", int'(out_change_5), 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sold_out", int'(sold_out), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // 5,5,5 on separate cycles; ack ignored in ACCUM; ack 3 cycles after request
        credit_q.push_back(5);
        credit_q.push_back(10);
        credit_q.push_back(15);
        credit_q.push_back(0);
        bottle_q.push_back(15);
        coin(1'b1, 1'b0);
        tick(3);
        disp_ack = 1'b1;
        tick(1);
        disp_ack = 1'b0;
        tick(1);
        check("ack_ignored_credit", int'(credit), 5);
        coin(1'b1, 1'b0);
        tick(3);
        coin(1'b1, 1'b0);
        wait_bottle();
        tick(3);
        check("busy_dispense", int'(busy), 1);
        ack();
        tick(2);
        check("t1_idle_busy", int'(busy), 0);
        check("t1_idle_bottle", int'(out_bottle), 0);

        // 5 and 10 in the same cycle
        credit_q.push_back(5);
        credit_q.push_back(15);
        credit_q.push_back(0);
        bottle_q.push_back(15);
        coin(1'b1, 1'b1);
        wait_bottle();
        ack();
        tick(2);

        // 10,10 -> one change pulse after the vend
        credit_q.push_back(10);
        credit_q.push_back(20);
        credit_q.push_back(5);
        credit_q.push_back(0);
        bottle_q.push_back(20);
        change_q.push_back(5);
        coin(1'b0, 1'b1);
        tick(3);
        coin(1'b0, 1'b1);
        wait_bottle();
        ack();
        tick(4);
        check("t3_credit", int'(credit), 0);

        // 10 then cancel in ACCUM -> two change pulses, no bottle
        credit_q.push_back(10);
        credit_q.push_back(5);
        credit_q.push_back(0);
        change_q.push_back(10);
        change_q.push_back(5);
        coin(1'b0, 1'b1);
        tick(3);
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        tick(4);
        check("t4_busy", int'(busy), 0);

        // Six coins in three cycles while dispensing: two rejected, four credited in order
        credit_q.push_back(10);
        credit_q.push_back(15);
        bottle_q.push_back(15);
        coin(1'b0, 1'b1);
        tick(3);
        coin(1'b1, 1'b0);
        wait_bottle();
        reject_q.push_back(1);
        reject_q.push_back(1);
        coin(1'b1, 1'b1);
        coin(1'b1, 1'b1);
        coin(1'b1, 1'b1);
        tick(3);
        check("t5_hold_bottle", int'(out_bottle), 1);
        credit_q.push_back(0);
        credit_q.push_back(5);
        credit_q.push_back(15);
        credit_q.push_back(0);
        credit_q.push_back(5);
        credit_q.push_back(15);
        credit_q.push_back(0);
        bottle_q.push_back(15);
        bottle_q.push_back(15);
        ack();
        wait_bottle();
        ack();
        wait_bottle();
        ack();
        tick(3);

        // Six bottles sold so far; four more empty the stock
        repeat (3) vend_10_5();
        check("stock1_not_sold_out", int'(sold_out), 0);
        vend_10_5();
        check("sold_out", int'(sold_out), 1);

        // Sold out: a 10 coin is refunded as two pulses
        credit_q.push_back(10);
        credit_q.push_back(5);
        credit_q.push_back(0);
        change_q.push_back(10);
        change_q.push_back(5);
        coin(1'b0, 1'b1);
        tick(5);
        check("refund_busy", int'(busy), 0);
        restock = 1'b1;
        tick(1);
        restock = 1'b0;
        check("restock_sold_out", int'(sold_out), 0);

        // Reset in the middle of a dispense
        credit_q.push_back(10);
        credit_q.push_back(15);
        credit_q.push_back(0);
        bottle_q.push_back(15);
        coin(1'b0, 1'b1);
        tick(3);
        coin(1'b1, 1'b0);
        wait_bottle();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("midrst_bottle", int'(out_bottle), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_credit", int'(credit), 0);
        tick(2);

`ifdef VEND_TIMEOUT_EN
        // Idle credit refunded after the timeout
        credit_q.push_back(5);
        credit_q.push_back(0);
        change_q.push_back(5);
        coin(1'b1, 1'b0);
        tick(TMO_CYC + 15);
        check("timeout_credit", int'(credit), 0);
`endif

        tick(5);
        check("credit_q_left", credit_q.size(), 0);
        check("bottle_q_left", bottle_q.size(), 0);
        check("change_q_left", change_q.size(), 0);
        check("reject_q_left", reject_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
